// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the mips_16 multiply/divide unit: op encodings,
// FSM state type and small op-decode helpers.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_MULLO = 2'b00;
  localparam logic [1:0] MDU_MULHU = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_REMU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } mdu_state_e;

  // Divide ops run the restoring-division datapath.
  function automatic logic op_is_div(logic [1:0] op);
    return (op == MDU_DIVU) || (op == MDU_REMU);
  endfunction

  // High half of the accumulator holds MULHU's product and REMU's remainder.
  function automatic logic op_takes_high(logic [1:0] op);
    return (op == MDU_MULHU) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake and operand/result bus of the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, result
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit, one bit per cycle.
// Multiply: shift-add into {carry, hi, lo}; the multiplier sits in lo and is
// consumed from the LSB. Divide: restoring; hi holds the partial remainder,
// lo shifts the dividend out and the quotient in.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  mult_div_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  mdu_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_iter;

  // One iteration of the selected datapath, computed from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, b_q};
    div_ge    = (div_trial >= {1'b0, b_q});
    if (op_is_div(op_q)) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    end else begin
      // Carry is shifted in at the top, so the full 2*WIDTH product is kept.
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    last_iter = (cnt_q == CntW'(WIDTH - 1));
  end

  // Next-state logic: abort wins everywhere; start only counts when not busy.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start && !bus.abort) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          acc_d   = {{WIDTH{1'b0}}, (op_is_div(bus.op) ? bus.a : bus.b)};
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d  = StDone;
            done_d   = 1'b1;
            result_d = op_takes_high(op_q) ? acc_step[2*WIDTH-1:WIDTH]
                                           : acc_step[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= MDU_MULLO;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int          LAT   = WIDTH + 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic launch(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
  endtask

  // Counts cycles after the launching cycle until done; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end while (!bus.done && lat < 60);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] exp);
    int lat;
    launch(o, x, y);
    wait_done(lat);
    check_eq({tag, "_lat"}, lat, LAT);
    check_eq(tag, bus.result, exp);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = MDU_MULLO;
    bus.a     = '0;
    bus.b     = '0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_result", bus.result, 0);

    run_op("mullo_300x500", MDU_MULLO, 16'd300, 16'd500, 16'h49F0);
    run_op("mulhu_300x500", MDU_MULHU, 16'd300, 16'd500, 16'h0002);
    run_op("mullo_ffff", MDU_MULLO, 16'hFFFF, 16'hFFFF, 16'h0001);
    run_op("mulhu_ffff", MDU_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    run_op("divu_1000_7", MDU_DIVU, 16'd1000, 16'd7, 16'd142);
    run_op("remu_1000_7", MDU_REMU, 16'd1000, 16'd7, 16'd6);
    run_op("divu_5_9", MDU_DIVU, 16'd5, 16'd9, 16'd0);
    run_op("remu_5_9", MDU_REMU, 16'd5, 16'd9, 16'd5);
    run_op("divu_by0", MDU_DIVU, 16'h1234, 16'd0, 16'hFFFF);
    run_op("remu_by0", MDU_REMU, 16'h1234, 16'd0, 16'h1234);

    // Start pulse mid-RUN with different operands must be ignored.
    launch(MDU_MULLO, 16'd300, 16'd500);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 5);
      if (lat == 5) begin
        bus.op = MDU_DIVU;
        bus.a  = 16'd1000;
        bus.b  = 16'd7;
      end
    end while (!bus.done && lat < 60);
    bus.start = 1'b0;
    check_eq("ignore_start_lat", lat, LAT);
    check_eq("ignore_start_res", bus.result, 16'h49F0);
    count_dones(25, n);
    check_eq("ignore_start_no_extra_done", n, 0);

    // Back-to-back: second start issued in the DONE cycle.
    launch(MDU_DIVU, 16'd1000, 16'd7);
    wait_done(lat);
    check_eq("b2b_first_lat", lat, LAT);
    check_eq("b2b_first_res", bus.result, 16'd142);
    bus.start = 1'b1;
    bus.op    = MDU_REMU;
    wait_done(lat);
    check_eq("b2b_second_lat", lat, LAT);
    check_eq("b2b_second_res", bus.result, 16'd6);

    // Abort at RUN cycle 8: no done, result keeps the previous value (6).
    launch(MDU_MULHU, 16'hFFFF, 16'hFFFF);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check_eq("abort_busy_before", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_busy_after", bus.busy, 0);
    count_dones(25, n);
    check_eq("abort_no_done", n, 0);
    check_eq("abort_result_held", bus.result, 16'd6);
    run_op("after_abort", MDU_MULLO, 16'd300, 16'd500, 16'h49F0);

    // Abort and start in the same IDLE cycle: start is dropped.
    launch(MDU_DIVU, 16'd1000, 16'd7);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("abort_start_idle_busy", bus.busy, 0);

    // Abort in the DONE cycle: pulse still seen, same-cycle start dropped.
    launch(MDU_REMU, 16'd1000, 16'd7);
    wait_done(lat);
    check_eq("abort_done_pulse", bus.done, 1);
    check_eq("abort_done_res", bus.result, 16'd6);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("abort_done_busy", bus.busy, 0);
    check_eq("abort_done_done", bus.done, 0);

    // Reset mid-RUN clears everything immediately.
    launch(MDU_MULLO, 16'hFFFF, 16'hFFFF);
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_done", bus.done, 0);
    check_eq("midrst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", MDU_DIVU, 16'd1000, 16'd7, 16'd142);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 16-bit unsigned multiply/divide unit for mips_16.
- Sits beside the combinational ALU in the EX stage and handles the operations that ALU does not: MULLO, MULHU, DIVU, REMU.
- Uses a start/busy/done handshake so the hazard unit can stall the pipeline while it runs.
- Computes one bit per cycle: shift-add for multiply, restoring division for divide.

Parameters:
- WIDTH, 16, operand/result width. The iteration count equals WIDTH. The counter width is $clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  operation: 00 MULLO, 01 MULHU, 10 DIVU, 11 REMU.
- a  input  WIDTH  src1 (multiplicand/dividend), captured at start.
- b  input  WIDTH  src2 (multiplier/divisor), captured at start.
- abort  input  1  synchronous kill (pipeline flush).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  selected result, held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0; counter, accumulator and operand registers cleared.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 and abort=0 → latch a, b, op; clear the 2*WIDTH accumulator; counter=0; go to RUN.
  - RUN: busy=1. One iteration per cycle; counter increments. After iteration WIDTH-1 → DONE.
  - DONE: done=1 for exactly one cycle; result register updated. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back; busy=0 in DONE).
- Latency: start sampled in cycle 0 → RUN in cycles 1..WIDTH → done=1 in cycle WIDTH+1 (17 for WIDTH=16). Throughput: one op per WIDTH+1 cycles.
- Multiply (shift-add, unsigned):
  - Each step: if multiplier LSB=1, add multiplicand to the upper half.
  - Then shift the {carry,acc} right by 1. The carry bit is retained, so no overflow loss.
  - MULLO = product[WIDTH-1:0]; MULHU = product[2*WIDTH-1:WIDTH].
- Divide (restoring, unsigned):
  - Each step: rem = {rem, next dividend bit}.
  - If rem >= divisor: subtract and shift in quotient bit 1; else shift in 0.
  - DIVU = quotient; REMU = remainder.
- Divide by zero: no trap and no special path. The natural restoring result is required: quotient = all ones (16'hFFFF), remainder = a. Latency is unchanged.
- start while busy=1: ignored; the operation in flight is unaffected.
- abort:
  - Highest priority in any state. Next cycle state=IDLE, busy=0.
  - No done is emitted for the killed op; result keeps its previous value.
  - abort and start in the same IDLE cycle: start is dropped.
  - abort in the DONE cycle: the done pulse still occurs that cycle (result already committed). Any same-cycle start is dropped.
- Reset mid-operation: immediate return to IDLE with reset values; no done.
- Undefined op values: none, since all 4 encodings are defined.
- Result and done are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared header (mips_16_defs): op encodings MDU_MULLO=2'b00, MDU_MULHU=2'b01, MDU_DIVU=2'b10, MDU_REMU=2'b11, and state encodings.
- Single module; no sub-module. The iteration datapath (one add/sub plus shift) is small enough to keep inline.

Test Plan:
- Reset: rst_n=0 asserted mid-RUN → busy=0, done=0, result=0 immediately. After release, IDLE accepts a new start.
- Multiply: a=300, b=500.
  - MULLO → result=16'h49F0, done exactly in cycle 17 after start.
  - MULHU → 16'h0002.
  - a=b=16'hFFFF → MULLO=16'h0001, MULHU=16'hFFFE.
- Divide: a=1000, b=7.
  - DIVU → 142 (16'h008E).
  - REMU → 6.
  - a=5, b=9 → DIVU=0, REMU=5.
- Divide by zero: a=16'h1234, b=0 → DIVU=16'hFFFF, REMU=16'h1234, latency 17.
- Handshake:
  - start pulses during RUN are ignored.
  - start in the DONE cycle begins the next op; its done follows 17 cycles later.
  - Two back-to-back ops give two done pulses 17 cycles apart.
- Abort: abort at RUN cycle 8 → busy=0 next cycle, no done, result unchanged. A new start is then accepted normally.
